// File: rtl/demux_1x4_seq_if.sv
// demux_1x4_seq_if: source and lane handshake bundle
// for the registered 1-to-4 demultiplexer.
interface demux_1x4_seq_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             s0;
  logic             s1;
  logic             auto_mode;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic [3:0]       q_valid;
  logic [3:0]       q_ready;
  logic [1:0]       cur_sel;

  modport master (
    output din, din_valid, s0, s1,
    output auto_mode, q_ready,
    input  din_ready, q0, q1, q2, q3,
    input  q_valid, cur_sel
  );

  modport slave (
    input  din, din_valid, s0, s1,
    input  auto_mode, q_ready,
    output din_ready, q0, q1, q2, q3,
    output q_valid, cur_sel
  );
endinterface

// File: rtl/demux_1x4_seq.sv
// demux_1x4_seq: registered 1-to-4 demux, explicit or
// round-robin lane select. Option: DEMUX_INVERT_IN_EN.
module demux_1x4_seq #(
  parameter int WIDTH = 1
) (
  input logic          clk,
  input logic          reset,
  demux_1x4_seq_if.slave bus
);

  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       vld_q;
  logic [3:0]       vld_d;
  logic [1:0]       rr_cnt;
  logic [1:0]       sel;
  logic             accept;
  logic [WIDTH-1:0] wdata;

  assign sel = bus.auto_mode ? rr_cnt
                             : {bus.s1, bus.s0};

  assign bus.cur_sel = sel;

  assign bus.din_ready = !vld_q[sel] ||
                         bus.q_ready[sel];

  assign accept = bus.din_valid && bus.din_ready;

`ifdef DEMUX_INVERT_IN_EN
  assign wdata = ~bus.din;
`else
  assign wdata = bus.din;
`endif

  assign bus.q0      = lane_q[0];
  assign bus.q1      = lane_q[1];
  assign bus.q2      = lane_q[2];
  assign bus.q3      = lane_q[3];
  assign bus.q_valid = vld_q;

  // Drains clear valid; a fill on the same lane wins.
  always_comb begin
    vld_d = vld_q & ~bus.q_ready;
    if (accept) begin
      vld_d[sel] = 1'b1;
    end
  end

  // Lane data, valid bits and round-robin counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        lane_q[n] <= '0;
      end
      vld_q  <= 4'b0000;
      rr_cnt <= 2'd0;
    end else begin
      vld_q <= vld_d;
      if (accept) begin
        lane_q[sel] <= wdata;
        if (bus.auto_mode) begin
          rr_cnt <= rr_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/demux_1x4_seq.md
Name: demux_1x4_seq

Overview:
Registered 1-to-4 demultiplexer: the receive-side counterpart of the mux_4x1 selection path. Routes each accepted input word to one of four output lanes, chosen either by explicit select pins (s1,s0) or by an internal round-robin lane counter. Each lane has a one-entry holding register with valid/ready handshake, so the block sits between a shared serial source and four independent consumers.

Parameters:
WIDTH, 1, data width of din and of each output lane q0..q3.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
din  input  WIDTH  input data word.
din_valid  input  1  din holds a valid word this cycle.
din_ready  output  1  block accepts din this cycle (combinational).
s0  input  1  explicit lane select, LSB.
s1  input  1  explicit lane select, MSB.
auto_mode  input  1  1 = lane taken from the round-robin counter; 0 = lane taken from {s1,s0}.
q0, q1, q2, q3  output  WIDTH each  lane holding registers.
q_valid  output  4  per-lane valid; bit n qualifies qn.
q_ready  input  4  per-lane consumer ready; bit n drains lane n.
cur_sel  output  2  lane targeted this cycle (combinational).

Behaviour:
- Clock and reset: single clock, clk. reset is asynchronous and active-high.
- Reset values: q0..q3 = 0, q_valid = 4'b0000, round-robin counter rr_cnt = 0. After reset, din_ready = 1 and cur_sel = {s1,s0} or 0, depending on auto_mode.
- Lane select:
  - sel = auto_mode ? rr_cnt : {s1,s0}.
  - cur_sel = sel.
  - Select and auto_mode changes take effect in the same cycle (no registering).
- Ready: din_ready = !q_valid[sel] || q_ready[sel].
  - Only the selected lane gates acceptance.
  - A full unselected lane never stalls the input.
- Accept: when din_valid && din_ready at a rising edge:
  - q[sel] <= din;
  - q_valid[sel] <= 1.
  - Latency from din to q[sel] is 1 cycle.
- Drain: for each lane n, q_valid[n] && q_ready[n] at an edge clears q_valid[n], unless lane n is also being written that edge.
  - Simultaneous drain and fill on the same lane: q_valid stays 1 and qn takes the new word. No bubble and no loss.
  - qn holds its last value after drain. Data is not cleared.
- No accept (din_valid=0, or din_ready=0): no lane register changes except drains. rr_cnt holds.
- Round-robin counter:
  - rr_cnt increments by 1 mod 4 on each accept while auto_mode=1.
  - Wraps 3 -> 0.
  - Holds while auto_mode=0.
  - Re-asserting auto_mode resumes from the held value, not from 0.
- Backpressure in auto mode: if lane rr_cnt is full and not draining, din_ready=0. The counter does not skip the full lane (strict ordering).
- Reset mid-operation: all held words are discarded, q_valid clears immediately (asynchronous), and rr_cnt returns to 0.
- State: the only sequential state is the four lane registers, the 4-bit q_valid and the 2-bit rr_cnt.

Optional Feature:
Macro DEMUX_INVERT_IN_EN.
- Defined: each lane captures ~din (bitwise) on accept. This restores true polarity when the upstream source is the inverting mux_4x1 output path.
- Not defined: lanes capture din unmodified.
- Handshake, select and counter behaviour are identical in both builds.

Test Plan:
1. Reset: assert reset mid-cycle with q_valid=4'b1010 -> q_valid=0, q0..q3=0 and rr_cnt=0 immediately, before the next clk edge; din_ready=1 after release.
2. Explicit select: auto_mode=0, WIDTH=8; send 0xA5 with {s1,s0}=2'b10, q_ready=0 -> next cycle q2=0xA5, q_valid=4'b0100. A second word to lane 2 sees din_ready=0 and is not taken. A word to lane 0 is accepted.
3. Round-robin wrap: auto_mode=1, q_ready=4'b1111; stream 0x01..0x05 back-to-back -> words land in lanes 0,1,2,3,0 on consecutive cycles; rr_cnt ends at 1.
4. Fill-while-drain: lane 1 holds 0x11, q_ready[1]=1, accept 0x22 to lane 1 in the same cycle -> q_valid[1] stays 1, q1=0x22, no stall.
5. Auto backpressure and hold: auto_mode=1 with rr_cnt=3 and lane 3 full, q_ready[3]=0 -> din_ready=0 and rr_cnt stays 3. Toggle auto_mode 1->0->1 -> rr_cnt still 3. Raise q_ready[3] -> accept proceeds and rr_cnt wraps to 0.
6. DEMUX_INVERT_IN_EN build: send 0x3C to lane 0 -> q0=0xC3. Without the macro, the same stimulus gives q0=0x3C.
